pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised program-counter sequencer for the MIPS fetch stage. Replaces the fixed 8-bit free-running counter.
//   Supports stall, PC-relative branch, absolute jump, and exception entry/return with an EPC register.
//   A small return-address stack (RAS) serves call/return. Feeds the instruction-memory address and the link-register write path.
// PARAMETERS
//   ADDR_W     32      PC / address width in bits
//   INC        4       sequential increment in bytes (one instruction word)
//   RST_VEC    0       PC value after reset
//   EXC_VEC    'h80    PC loaded on exception entry
//   RAS_DEPTH  4       return-address stack entries (power of 2, >=2)
// PORTS
//   clk          in   1           clock, rising edge
//   rst          in   1           reset, asynchronous, active-high
//   en           in   1           advance enable; 0 = stall (PC, RAS hold)
//   branch_i     in   1           take branch: PC <= PC + INC + (off<<2)
//   branch_off_i in   ADDR_W      signed word offset (two's complement)
//   jump_i       in   1           absolute jump: PC <= jump_target_i
//   jump_target_i in  ADDR_W      jump destination (byte address)
//   call_i       in   1           with jump_i: push PC+INC onto RAS
//   ret_i        in   1           return: PC <= RAS top (pop); fallback ret_target_i
//   ret_target_i in   ADDR_W      register-file return address (jr $ra)
//   exc_i        in   1           exception: EPC <= PC, PC <= EXC_VEC
//   eret_i       in   1           exception return: PC <= EPC
//   pc_o         out  ADDR_W      current PC (registered)
//   link_o       out  ADDR_W      PC + INC (combinational, for jal link)
//   epc_o        out  ADDR_W      exception PC register
//   ras_count_o  out  clog2(D)+1  valid RAS entries
//   ras_uflow_o  out  1           pulse: ret_i accepted with RAS empty
//   misalign_o   out  1           pc_o[1:0] != 0 (combinational)
// BEHAVIOUR
//   Reset (async, any time, incl. mid-sequence): pc_o=RST_VEC, epc_o=0, ras_count_o=0, ras_uflow_o=0; RAS contents don't-care.
//   All updates on posedge clk. Latency 1: the next-PC selection is visible on pc_o the following cycle.
//   Next-PC priority, highest first:
//     1 exc_i   : acts even when en=0; EPC<=pc_o, PC<=EXC_VEC; RAS unchanged
//     2 eret_i  : (en=1) PC<=epc_o
//     3 ret_i   : (en=1) RAS non-empty: PC<=top, pop; empty: PC<=ret_target_i, ras_uflow_o=1 for 1 cycle
//     4 jump_i  : (en=1) PC<=jump_target_i; if call_i also push PC+INC
//     5 branch_i: (en=1) PC<=PC+INC+(sign-ext off<<2)
//     6 none    : (en=1) PC<=PC+INC
//   en=0 with no exc_i: PC, EPC, RAS, count all hold; ras_uflow_o=0.
//   Lower-priority requests in the same cycle are dropped, never queued (e.g. exc_i+call_i: no push).
//   call_i without jump_i is ignored.
//   Arithmetic: all sums modulo 2^ADDR_W; wrap at top of address space is silent (0xFFFFFFFC+4 -> 0).
//   RAS is circular. Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
//   Pop decrements count. ret_i + jump_i + call_i in the same cycle: ret wins, no push.
//   misalign_o flags only; no redirect. Upstream raises exc_i if required.
// TESTING
//   1 rst pulse mid-count, then en=1 x5 -> pc_o = 0,4,8,12,16,20; rst asserted async -> pc_o=0 before next edge
//   2 pc_o=0x100, branch_i, off=-3 -> pc_o=0xF8; off=+2 -> 0x104+8=0x10C
//   3 pc_o=0x40: jump_i+call_i to 0x200 -> pc_o=0x200, count=1; ret_i -> pc_o=0x44, count=0
//   4 5 calls, RAS_DEPTH=4 -> count=4; 4 rets return newest four links; 5th ret -> pc_o=ret_target_i, ras_uflow_o=1
//   5 en=0, exc_i at pc_o=0x1234 -> pc_o=0x80, epc_o=0x1234; en=1, eret_i -> pc_o=0x1234
//   6 pc_o=0xFFFFFFFC, en=1 -> pc_o=0; en=0 for 3 cycles -> pc_o holds 0, RAS unchanged

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS fetch program-counter sequencer with EPC and return-address stack
// Priority: exception > eret > return > jump(/call) > branch > sequential; en=0 stalls all but exceptions.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       INC       = 4,
    parameter logic [ADDR_W-1:0] RST_VEC   = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h80),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        branch_i,
    input  logic [ADDR_W-1:0]           branch_off_i,
    input  logic                        jump_i,
    input  logic [ADDR_W-1:0]           jump_target_i,
    input  logic                        call_i,
    input  logic                        ret_i,
    input  logic [ADDR_W-1:0]           ret_target_i,
    input  logic                        exc_i,
    input  logic                        eret_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic [ADDR_W-1:0]           link_o,
    output logic [ADDR_W-1:0]           epc_o,
    output logic [$clog2(RAS_DEPTH):0]  ras_count_o,
    output logic                        ras_uflow_o,
    output logic                        misalign_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              uflow_q, uflow_d;
    logic              push;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    assign link_o      = pc_q + ADDR_W'(INC);
    assign pc_o        = pc_q;
    assign epc_o       = epc_q;
    assign ras_count_o = cnt_q;
    assign ras_uflow_o = uflow_q;
    assign misalign_o  = |pc_q[1:0];
    // sp_q points at the next free slot, so the top lives one below it (circularly).
    assign top_idx     = sp_q - PTR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        uflow_d = 1'b0;
        push    = 1'b0;
        if (exc_i) begin
            epc_d = pc_q;
            pc_d  = EXC_VEC;
        end else if (en) begin
            if (eret_i) begin
                pc_d = epc_q;
            end else if (ret_i) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_mem[top_idx];
                    sp_d  = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pc_d    = ret_target_i;
                    uflow_d = 1'b1;
                end
            end else if (jump_i) begin
                pc_d = jump_target_i;
                if (call_i) begin
                    push = 1'b1;
                    sp_d = sp_q + PTR_W'(1);
                    // A full stack overwrites its oldest entry; the count just saturates.
                    cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end else if (branch_i) begin
                pc_d = link_o + (branch_off_i << 2);
            end else begin
                pc_d = link_o;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RST_VEC;
            epc_q   <= '0;
            sp_q    <= '0;
            cnt_q   <= '0;
            uflow_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            uflow_q <= uflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp_q] <= link_o;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;

    localparam int A = 32;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, branch_i = 1'b0, jump_i = 1'b0, call_i = 1'b0;
    logic ret_i = 1'b0, exc_i = 1'b0, eret_i = 1'b0;
    logic [A-1:0] branch_off_i = '0, jump_target_i = '0, ret_target_i = '0;
    logic [A-1:0] pc_o, link_o, epc_o;
    logic [$clog2(D):0] ras_count_o;
    logic ras_uflow_o, misalign_o;

    int checks = 0;
    int errors = 0;

    logic [A-1:0] m_pc, m_epc;
    logic [A-1:0] m_ras[$];
    logic m_uflow;

    pc_sequencer #(.ADDR_W(A), .INC(4), .RST_VEC('0), .EXC_VEC(32'h80), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en),
        .branch_i(branch_i), .branch_off_i(branch_off_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i), .call_i(call_i),
        .ret_i(ret_i), .ret_target_i(ret_target_i),
        .exc_i(exc_i), .eret_i(eret_i),
        .pc_o(pc_o), .link_o(link_o), .epc_o(epc_o),
        .ras_count_o(ras_count_o), .ras_uflow_o(ras_uflow_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = '0; m_epc = '0; m_uflow = 1'b0; m_ras.delete();
    endtask

    task automatic idle();
        en = 1'b1; branch_i = 0; jump_i = 0; call_i = 0; ret_i = 0; exc_i = 0; eret_i = 0;
    endtask

    // Advance the model from the rules, then clock the DUT and settle past the edge.
    task automatic cycle();
        m_uflow = 1'b0;
        if (exc_i) begin
            m_epc = m_pc;
            m_pc  = 32'h80;
        end else if (en) begin
            if (eret_i) m_pc = m_epc;
            else if (ret_i) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = ret_target_i; m_uflow = 1'b1; end
            end else if (jump_i) begin
                if (call_i) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > D) void'(m_ras.pop_front());
                end
                m_pc = jump_target_i;
            end else if (branch_i) m_pc = m_pc + 32'd4 + (branch_off_i << 2);
            else m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [A-1:0] addr);
        idle(); jump_i = 1; jump_target_i = addr; cycle(); idle();
    endtask

    task automatic test_reset();
        idle();
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1;
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_async_pc: got %h want 0", pc_o); end
        checks++; if (epc_o !== 32'h0 || ras_count_o !== 0 || ras_uflow_o !== 0) begin
            errors++; $display("FAIL reset_state: epc %h cnt %0d uflow %0d want 0", epc_o, ras_count_o, ras_uflow_o); end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_hold_pc: got %h want 0", pc_o); end
        for (int i = 1; i <= 5; i++) begin
            cycle();
            checks++; if (pc_o !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_o, 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        go_to(32'h100);
        branch_i = 1; branch_off_i = -32'sd3; cycle(); idle();
        checks++; if (pc_o !== 32'hF8) begin errors++; $display("FAIL branch_neg: got %h want f8", pc_o); end
        go_to(32'h100);
        branch_i = 1; branch_off_i = 32'd2; cycle(); idle();
        checks++; if (pc_o !== 32'h10C) begin errors++; $display("FAIL branch_pos: got %h want 10c", pc_o); end
    endtask

    task automatic test_call_ret();
        go_to(32'h40);
        jump_i = 1; call_i = 1; jump_target_i = 32'h200; cycle(); idle();
        checks++; if (pc_o !== 32'h200 || ras_count_o !== 1) begin
            errors++; $display("FAIL call: pc %h cnt %0d want 200/1", pc_o, ras_count_o); end
        ret_i = 1; ret_target_i = 32'hDEAD0000; cycle(); idle();
        checks++; if (pc_o !== 32'h44 || ras_count_o !== 0 || ras_uflow_o !== 0) begin
            errors++; $display("FAIL ret: pc %h cnt %0d uflow %0d want 44/0/0", pc_o, ras_count_o, ras_uflow_o); end
    endtask

    task automatic test_ras_overflow();
        for (int k = 1; k <= 5; k++) begin
            idle(); jump_i = 1; call_i = 1; jump_target_i = 32'(k * 32'h1000); cycle();
        end
        idle();
        checks++; if (ras_count_o !== 3'(D)) begin errors++; $display("FAIL ras_full: cnt %0d want %0d", ras_count_o, D); end
        // Newest link is 0x4000+4, oldest surviving is 0x1000+4.
        for (int k = 4; k >= 1; k--) begin
            ret_i = 1; ret_target_i = 32'hBAD0; cycle();
            checks++; if (pc_o !== 32'(k * 32'h1000 + 4) || pc_o !== m_pc) begin
                errors++; $display("FAIL ras_pop[%0d]: got %h want %h", k, pc_o, 32'(k * 32'h1000 + 4)); end
        end
        ret_i = 1; ret_target_i = 32'h0000_3000; cycle(); idle();
        checks++; if (pc_o !== 32'h3000 || ras_uflow_o !== 1 || ras_count_o !== 0) begin
            errors++; $display("FAIL ras_uflow: pc %h uflow %0d cnt %0d want 3000/1/0", pc_o, ras_uflow_o, ras_count_o); end
        cycle();
        checks++; if (ras_uflow_o !== 0) begin errors++; $display("FAIL uflow_pulse: got %0d want 0", ras_uflow_o); end
    endtask

    task automatic test_exception();
        go_to(32'h1234);
        en = 0; exc_i = 1; cycle(); idle();
        checks++; if (pc_o !== 32'h80 || epc_o !== 32'h1234) begin
            errors++; $display("FAIL exc: pc %h epc %h want 80/1234", pc_o, epc_o); end
        eret_i = 1; cycle(); idle();
        checks++; if (pc_o !== 32'h1234) begin errors++; $display("FAIL eret: got %h want 1234", pc_o); end
    endtask

    task automatic test_wrap_stall();
        jump_i = 1; call_i = 1; jump_target_i = 32'hFFFF_FFFC; cycle(); idle();
        cycle();
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap: got %h want 0", pc_o); end
        en = 0; ret_i = 1;
        repeat (3) cycle();
        checks++; if (pc_o !== 32'h0 || ras_count_o !== 1 || ras_uflow_o !== 0) begin
            errors++; $display("FAIL stall: pc %h cnt %0d uflow %0d want 0/1/0", pc_o, ras_count_o, ras_uflow_o); end
        idle(); ret_i = 1; cycle(); idle();
        checks++; if (pc_o !== 32'h1238) begin errors++; $display("FAIL stall_ras_kept: got %h want 1238", pc_o); end
    endtask

    task automatic test_priority();
        go_to(32'h500);
        exc_i = 1; jump_i = 1; call_i = 1; jump_target_i = 32'h900; cycle(); idle();
        checks++; if (pc_o !== 32'h80 || ras_count_o !== 0) begin
            errors++; $display("FAIL exc_over_call: pc %h cnt %0d want 80/0", pc_o, ras_count_o); end
        call_i = 1; cycle(); idle();
        checks++; if (pc_o !== 32'h84 || ras_count_o !== 0) begin
            errors++; $display("FAIL call_no_jump: pc %h cnt %0d want 84/0", pc_o, ras_count_o); end
        ret_i = 1; jump_i = 1; call_i = 1; ret_target_i = 32'h777C; jump_target_i = 32'h900; cycle(); idle();
        checks++; if (pc_o !== 32'h777C || ras_count_o !== 0 || ras_uflow_o !== 1) begin
            errors++; $display("FAIL ret_over_call: pc %h cnt %0d uflow %0d want 777c/0/1", pc_o, ras_count_o, ras_uflow_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en            = ($urandom_range(0, 9) < 8);
            exc_i         = ($urandom_range(0, 19) == 0);
            eret_i        = ($urandom_range(0, 14) == 0);
            ret_i         = ($urandom_range(0, 5) == 0);
            jump_i        = ($urandom_range(0, 4) == 0);
            call_i        = $urandom_range(0, 1);
            branch_i      = ($urandom_range(0, 3) == 0);
            branch_off_i  = 32'($urandom_range(0, 64)) - 32'd32;
            jump_target_i = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            ret_target_i  = $urandom & 32'hFFFF_FFFC;
            cycle();
            checks++;
            if (pc_o !== m_pc || epc_o !== m_epc || ras_count_o !== 3'(m_ras.size())
                || ras_uflow_o !== m_uflow || link_o !== m_pc + 32'd4 || misalign_o !== (m_pc[1:0] != 2'b00)) begin
                errors++;
                $display("FAIL random[%0d]: pc %h/%h epc %h/%h cnt %0d/%0d uflow %0d/%0d link %h mis %0d",
                         i, pc_o, m_pc, epc_o, m_epc, ras_count_o, m_ras.size(), ras_uflow_o, m_uflow, link_o, misalign_o);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_exception();
        test_wrap_stall();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
